// File: rtl/lcd_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// lcd_cmd_sequencer
//
// Drives an ST7789 SPI LCD through its bring-up and frame updates. After a
// hardware reset pulse it plays the init command table out of a constant ROM.
// On each frame_start it then writes the CASET/RASET/RAMWR window, followed by
// the RGB565 pixel stream taken from the pixel source. The block sits between
// the pixel source and the SPI byte shifter, and it owns lcd_resn and the D/C
// line.
//
// Ports
//   clk_spi      in   system clock
//   resn         in   asynchronous active-low reset
//   clk_spi_ena  in   clock enable, all state advances only when 1
//   frame_start  in   one-cycle pulse that starts window set + frame transfer
//   pix_valid    in   pixel source has pix_data
//   pix_data     in   16-bit RGB565 pixel
//   pix_ready    out  pixel slot open (valid & ready & ena = transfer)
//   tx_valid     out  byte to SPI shifter valid
//   tx_data      out  byte to shift, MSB first
//   tx_dc        out  0 = command byte, 1 = parameter/pixel byte
//   tx_ready     in   shifter can accept a byte
//   lcd_resn     out  LCD hardware reset, active low
//   init_done    out  init table complete, sticky until reset
//   busy         out  low only while idle
//
// ROM record format: cmd byte (dc=0); count byte, which is not sent
// ([6:0] = arg count N, [7] = delay flag); N argument bytes (dc=1); and, when
// the flag is set, one delay byte D. D is a wait in ms, 255 = 500 ms, 0 = none.
// c_init_data holds the ROM with byte 0 in the most significant position, so
// a literal reads in table order.
// ---------------------------------------------------------------------------
module lcd_cmd_sequencer #(
    parameter int c_clk_spi_mhz = 120,
    parameter int c_reset_us    = 1000,
    parameter int c_init_size   = 35,
    parameter logic [8*c_init_size-1:0] c_init_data =
        280'h018096_1180FF_3A81550A_3681000A_2A04000000EF_2B04000000EF_21800A_13800A_298064,
    parameter int c_x_size      = 240,
    parameter int c_y_size      = 240,
    parameter int c_x_offset    = 0,
    parameter int c_y_offset    = 0
) (
    input  logic        clk_spi,
    input  logic        resn,
    input  logic        clk_spi_ena,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    output logic        pix_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_dc,
    input  logic        tx_ready,
    output logic        lcd_resn,
    output logic        init_done,
    output logic        busy
);

    localparam int c_ptr_w     = $clog2(c_init_size + 1);
    localparam int c_pix_total = c_x_size * c_y_size;
    localparam int c_pix_w     = $clog2(c_pix_total + 1);

    localparam logic [31:0] c_pre_max     = 32'(c_clk_spi_mhz - 1);
    localparam logic [31:0] c_reset_ticks = 32'(c_reset_us);

    localparam logic [15:0] c_x0 = 16'(c_x_offset);
    localparam logic [15:0] c_x1 = 16'(c_x_offset + c_x_size - 1);
    localparam logic [15:0] c_y0 = 16'(c_y_offset);
    localparam logic [15:0] c_y1 = 16'(c_y_offset + c_y_size - 1);

    localparam logic [c_ptr_w-1:0] c_rom_end  = c_ptr_w'(c_init_size);
    localparam logic [c_pix_w-1:0] c_pix_last = c_pix_w'(c_pix_total - 1);

    typedef enum logic [3:0] {
        RST_LO, RST_WAIT, INIT_CMD, INIT_CNT, INIT_ARG, INIT_DLY,
        IDLE, WIN, PIX_LATCH, PIX_HI, PIX_LO
    } state_t;

    state_t             state, state_d;
    logic [c_ptr_w-1:0] ptr, ptr_d;
    logic [6:0]         arg_cnt, arg_cnt_d;
    logic               dly_flag, dly_flag_d;
    logic [31:0]        pre_cnt, pre_cnt_d;
    logic [31:0]        tick_cnt, tick_cnt_d;
    logic [31:0]        dly_ticks, dly_ticks_d;
    logic [3:0]         win_idx, win_idx_d;
    logic [c_pix_w-1:0] pix_cnt, pix_cnt_d;
    logic               init_done_d;
    logic [15:0]        pix_word;

    logic        tick;
    logic        dly_done;
    logic [31:0] dly_target;
    logic        rom_end;
    logic [7:0]  rom_cur;

    // ROM lookup; reads past the table return 0 (callers check rom_end first)
    function automatic logic [7:0] rom_byte(input logic [c_ptr_w-1:0] idx);
        if (idx >= c_rom_end)
            return 8'h00;
        return c_init_data[8*(c_init_size - 1 - int'(idx)) +: 8];
    endfunction

    // Delay byte to microsecond ticks; 255 is the ST7789 long-wait code
    function automatic logic [31:0] dly_us(input logic [7:0] d);
        if (d == 8'hFF)
            return 32'd500000;
        return 32'(d) * 32'd1000;
    endfunction

    // Window set byte sequence as {dc, data}
    function automatic logic [8:0] win_byte(input logic [3:0] idx);
        case (idx)
            4'd0:    return {1'b0, 8'h2A};
            4'd1:    return {1'b1, c_x0[15:8]};
            4'd2:    return {1'b1, c_x0[7:0]};
            4'd3:    return {1'b1, c_x1[15:8]};
            4'd4:    return {1'b1, c_x1[7:0]};
            4'd5:    return {1'b0, 8'h2B};
            4'd6:    return {1'b1, c_y0[15:8]};
            4'd7:    return {1'b1, c_y0[7:0]};
            4'd8:    return {1'b1, c_y1[15:8]};
            4'd9:    return {1'b1, c_y1[7:0]};
            4'd10:   return {1'b0, 8'h2C};
            default: return 9'h000;
        endcase
    endfunction

    assign lcd_resn = (state != RST_LO);
    assign busy     = (state != IDLE);

    always_comb begin
        state_d     = state;
        ptr_d       = ptr;
        arg_cnt_d   = arg_cnt;
        dly_flag_d  = dly_flag;
        pre_cnt_d   = 32'd0;
        tick_cnt_d  = tick_cnt;
        dly_ticks_d = dly_ticks;
        win_idx_d   = win_idx;
        pix_cnt_d   = pix_cnt;
        init_done_d = init_done;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        tx_dc       = 1'b0;
        pix_ready   = 1'b0;

        rom_cur = rom_byte(ptr);
        rom_end = (ptr >= c_rom_end);

        // Shared us timer: the prescaler produces one tick per microsecond,
        // and tick_cnt counts ticks up to the target of the current wait.
        tick       = (pre_cnt >= c_pre_max);
        dly_target = (state == INIT_DLY) ? dly_ticks : c_reset_ticks;
        dly_done   = tick && ((tick_cnt + 32'd1) >= dly_target);

        case (state)
            RST_LO, RST_WAIT, INIT_DLY: begin
                pre_cnt_d = tick ? 32'd0 : pre_cnt + 32'd1;
                if (dly_done)
                    tick_cnt_d = 32'd0;
                else if (tick)
                    tick_cnt_d = tick_cnt + 32'd1;
                if (dly_done)
                    state_d = (state == RST_LO) ? RST_WAIT : INIT_CMD;
            end
            INIT_CMD: begin
                if (rom_end) begin
                    state_d     = IDLE;
                    init_done_d = 1'b1;
                end else begin
                    tx_valid = 1'b1;
                    tx_data  = rom_cur;
                    if (tx_ready) begin
                        ptr_d   = ptr + 1'b1;
                        state_d = INIT_CNT;
                    end
                end
            end
            INIT_CNT: begin
                if (rom_end) begin
                    state_d     = IDLE;
                    init_done_d = 1'b1;
                end else begin
                    arg_cnt_d  = rom_cur[6:0];
                    dly_flag_d = rom_cur[7];
                    ptr_d      = ptr + 1'b1;
                    state_d    = INIT_ARG;
                end
            end
            INIT_ARG: begin
                if (rom_end && (arg_cnt != 7'd0 || dly_flag)) begin
                    // truncated record: stop cleanly instead of wrapping
                    state_d     = IDLE;
                    init_done_d = 1'b1;
                end else if (arg_cnt != 7'd0) begin
                    tx_valid = 1'b1;
                    tx_data  = rom_cur;
                    tx_dc    = 1'b1;
                    if (tx_ready) begin
                        ptr_d     = ptr + 1'b1;
                        arg_cnt_d = arg_cnt - 7'd1;
                    end
                end else if (dly_flag) begin
                    ptr_d       = ptr + 1'b1;
                    dly_flag_d  = 1'b0;
                    dly_ticks_d = dly_us(rom_cur);
                    tick_cnt_d  = 32'd0;
                    state_d     = (rom_cur == 8'h00) ? INIT_CMD : INIT_DLY;
                end else begin
                    state_d = INIT_CMD;
                end
            end
            IDLE: begin
                if (frame_start) begin
                    win_idx_d = 4'd0;
                    state_d   = WIN;
                end
            end
            WIN: begin
                tx_valid         = 1'b1;
                {tx_dc, tx_data} = win_byte(win_idx);
                if (tx_ready) begin
                    if (win_idx == 4'd10) begin
                        pix_cnt_d = '0;
                        state_d   = PIX_LATCH;
                    end else begin
                        win_idx_d = win_idx + 4'd1;
                    end
                end
            end
            PIX_LATCH: begin
                pix_ready = 1'b1;
                if (pix_valid)
                    state_d = PIX_HI;
            end
            PIX_HI: begin
                tx_valid = 1'b1;
                tx_data  = pix_word[15:8];
                tx_dc    = 1'b1;
                if (tx_ready)
                    state_d = PIX_LO;
            end
            PIX_LO: begin
                tx_valid = 1'b1;
                tx_data  = pix_word[7:0];
                tx_dc    = 1'b1;
                if (tx_ready) begin
                    if (pix_cnt == c_pix_last) begin
                        state_d = IDLE;
                    end else begin
                        pix_cnt_d = pix_cnt + 1'b1;
                        state_d   = PIX_LATCH;
                    end
                end
            end
            default: state_d = RST_LO;
        endcase
    end

    always_ff @(posedge clk_spi or negedge resn) begin
        if (!resn) begin
            state     <= RST_LO;
            ptr       <= '0;
            arg_cnt   <= 7'd0;
            dly_flag  <= 1'b0;
            pre_cnt   <= 32'd0;
            tick_cnt  <= 32'd0;
            dly_ticks <= 32'd0;
            win_idx   <= 4'd0;
            pix_cnt   <= '0;
            init_done <= 1'b0;
        end else if (clk_spi_ena) begin
            state     <= state_d;
            ptr       <= ptr_d;
            arg_cnt   <= arg_cnt_d;
            dly_flag  <= dly_flag_d;
            pre_cnt   <= pre_cnt_d;
            tick_cnt  <= tick_cnt_d;
            dly_ticks <= dly_ticks_d;
            win_idx   <= win_idx_d;
            pix_cnt   <= pix_cnt_d;
            init_done <= init_done_d;
        end
    end

    // Pixel holding register: it is only read in PIX_HI/PIX_LO after a
    // latch, so it needs no reset.
    always_ff @(posedge clk_spi) begin
        if (clk_spi_ena && state == PIX_LATCH && pix_valid)
            pix_word <= pix_data;
    end

endmodule
